// File: rtl/cm3_matrix_param_decoder_if.sv
// Input-stage side of one bus-matrix decoder: address-phase request from the
// input stage and the data-phase response returned to it.
interface cm3_matrix_param_decoder_if #(
    parameter int DW = 32,
    parameter int UW = 32
);
    logic          HREADYS;
    logic          sel_dec;
    logic [21:0]   decode_addr_dec;
    logic [1:0]    trans_dec;
    logic          active_dec;
    logic          HREADYOUTS;
    logic [1:0]    HRESPS;
    logic [DW-1:0] HRDATAS;
    logic [UW-1:0] HRUSERS;

    modport master (
        output HREADYS, sel_dec, decode_addr_dec, trans_dec,
        input  active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
    );

    modport slave (
        input  HREADYS, sel_dec, decode_addr_dec, trans_dec,
        output active_dec, HREADYOUTS, HRESPS, HRDATAS, HRUSERS
    );
endinterface

// File: rtl/cm3_matrix_param_decoder.sv
// Bus-matrix output decoder for one input port: region-table address decode,
// data-phase response mux, integrated two-cycle ERROR default slave and error counter.
module cm3_matrix_param_decoder #(
    parameter int                        NUM_PORTS    = 3,
    parameter int                        DW           = 32,
    parameter int                        UW           = 32,
    parameter logic [NUM_PORTS*22-1:0]   REGION_BASE  = {22'h100000, 22'h000040, 22'h000000},
    parameter logic [NUM_PORTS*22-1:0]   REGION_LIMIT = {22'h10003F, 22'h00007F, 22'h00003F},
    parameter int                        CNT_W        = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    cm3_matrix_param_decoder_if.slave bus,
    input  logic [NUM_PORTS-1:0]    active_in,
    input  logic [NUM_PORTS-1:0]    readyout_in,
    input  logic [2*NUM_PORTS-1:0]  resp_in,
    input  logic [DW*NUM_PORTS-1:0] rdata_in,
    input  logic [UW*NUM_PORTS-1:0] ruser_in,
    input  logic                    err_clr,
    output logic [NUM_PORTS-1:0]    sel_out,
    output logic [CNT_W-1:0]        err_count
);

    localparam int PW = $clog2(NUM_PORTS + 1);
    typedef logic [PW-1:0] port_idx_t;

    // The default slave takes the index just past the last real output stage.
    localparam port_idx_t DFT = port_idx_t'(NUM_PORTS);

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } dft_state_t;

    port_idx_t  addr_port;
    port_idx_t  data_port;
    logic       sel_dft;
    logic       dft_accept;
    logic       err_start;
    logic       dft_ready;
    logic [1:0] dft_resp;
    dft_state_t state;
    dft_state_t state_nxt;

    // Scanning downward lets the lowest matching index overwrite the rest.
    // An IDLE transfer keeps pointing at the stage that owns the data phase.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        addr_port = DFT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (((bus.decode_addr_dec >= REGION_BASE[i*22 +: 22]) &&
                 (bus.decode_addr_dec <= REGION_LIMIT[i*22 +: 22])) ||
                ((data_port == port_idx_t'(i)) && (bus.trans_dec == TRANS_IDLE))) begin
                addr_port = port_idx_t'(i);
            end
        end
    end

    always_comb begin
        sel_out        = '0;
        bus.active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_port == port_idx_t'(i)) begin
                sel_out[i]     = bus.sel_dec;
                bus.active_dec = active_in[i];
            end
        end
    end

    assign sel_dft    = bus.sel_dec && (addr_port == DFT);
    assign dft_accept = sel_dft && bus.HREADYS && bus.trans_dec[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!HRESETn) begin
            data_port <= '0;
        end else if (bus.HREADYS) begin
            data_port <= addr_port;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ERROR is two cycles: wait with ERROR, then ready with ERROR.
    always_comb begin
        state_nxt = state;
        dft_ready = 1'b1;
        dft_resp  = RESP_OKAY;
        err_start = 1'b0;
        case (state)
            DS_IDLE: begin
                if (dft_accept) begin
                    state_nxt = DS_ERR1;
                    err_start = 1'b1;
                end
            end
            DS_ERR1: begin
                dft_ready = 1'b0;
                dft_resp  = RESP_ERROR;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                dft_resp = RESP_ERROR;
                if (dft_accept) begin
                    state_nxt = DS_ERR1;
                    err_start = 1'b1;
                end else begin
                    state_nxt = DS_IDLE;
                end
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (err_start && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

    // Data-phase response follows the stage latched at the last accepted address phase.
    always_comb begin
        bus.HREADYOUTS = dft_ready;
        bus.HRESPS     = dft_resp;
        bus.HRDATAS    = '0;
        bus.HRUSERS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port == port_idx_t'(i)) begin
                bus.HREADYOUTS = readyout_in[i];
                bus.HRESPS     = resp_in[2*i +: 2];
                bus.HRDATAS    = rdata_in[DW*i +: DW];
                bus.HRUSERS    = ruser_in[UW*i +: UW];
            end
        end
    end

endmodule
